operand_stage: RTL and testbench

- Parametrised decode-to-execute operand stage for the RV64 pipeline.
- Generates all RISC-V immediate formats and selects operand A/B, with W-mode and division sign/zero extension.
- Forwards from EX/MEM and tracks outstanding register writes in a per-register pending-count scoreboard.
- Holds one instruction in an output register with valid/ready handshakes on both sides; raises stall when a source is not yet available.

---
 rtl/operand_stage_if.sv | 42 ++++
 rtl/operand_stage.sv | 190 +++++++++++++++++++
 tb/tb_operand_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_stage_if.sv
// Decode-to-execute operand bundle: upstream instruction fields in, resolved operands out.
// The stage itself connects through the slave modport.
interface operand_stage_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     in_pc;
  logic [31:0]     in_instr;
  logic [2:0]      in_imm_type;
  logic [1:0]      in_sel_a;
  logic [1:0]      in_sel_b;
  logic            in_use_rs1;
  logic            in_use_rs2;
  logic            in_wmode;
  logic [1:0]      in_ext;
  logic            in_rd_we;

  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_pc;
  logic [4:0]      out_rd;
  logic            out_rd_we;
  logic            out_wmode;
  logic [XLEN-1:0] out_rd1;
  logic [XLEN-1:0] out_rd2;
  logic [XLEN-1:0] out_imm;

  modport master (
    output in_valid, in_pc, in_instr, in_imm_type, in_sel_a, in_sel_b,
           in_use_rs1, in_use_rs2, in_wmode, in_ext, in_rd_we, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rd_we, out_wmode,
           out_rd1, out_rd2, out_imm
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_imm_type, in_sel_a, in_sel_b,
           in_use_rs1, in_use_rs2, in_wmode, in_ext, in_rd_we, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rd_we, out_wmode,
           out_rd1, out_rd2, out_imm
  );
endinterface

// File: rtl/operand_stage.sv
// RV64 operand stage: immediate generation, EX/MEM forwarding, pending-write scoreboard
// and a single-entry output register with valid/ready on both sides.
module operand_stage #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  operand_stage_if.slave    bus,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  logic              ex_fwd_valid,
  input  logic              ex_fwd_ready,
  input  logic [4:0]        ex_fwd_rd,
  input  logic [XLEN-1:0]   ex_fwd_data,
  input  logic              mem_fwd_valid,
  input  logic              mem_fwd_ready,
  input  logic [4:0]        mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  output logic              stall
);

  localparam logic [CNT_W-1:0] PMAX = '1;

  function automatic logic signed [XLEN-1:0] imm_gen(input logic [31:0] ins,
                                                      input logic [2:0]  t);
    logic signed [31:0] v;
    v = '0;
    case (t)
      3'd1:    v = {{20{ins[31]}}, ins[31:20]};
      3'd2:    v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'd3:    v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd4:    v = {ins[31:12], 12'b0};
      3'd5:    v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: v = '0;
    endcase
    return XLEN'(v);
  endfunction

  // Only meaningful on a 64-bit datapath; a 32-bit build passes operands through.
  function automatic logic signed [XLEN-1:0] ext_op(input logic signed [XLEN-1:0] v,
                                                     input logic [1:0]               e);
    logic signed [XLEN-1:0] r;
    r = v;
    if (XLEN > 32) begin
      if (e == 2'd1)      r = XLEN'($signed(v[31:0]));
      else if (e == 2'd2) r = XLEN'(v[31:0]);
    end
    return r;
  endfunction

  logic                   vld_p1;
  logic [63:0]            pc_p1;
  logic [4:0]             rd_p1;
  logic                   rd_we_p1;
  logic                   wmode_p1;
  logic signed [XLEN-1:0] rd1_p1;
  logic signed [XLEN-1:0] rd2_p1;
  logic signed [XLEN-1:0] imm_p1;

  logic [CNT_W-1:0]       pend [NREG];

  logic [4:0]             rs      [2];
  logic [XLEN-1:0]        rf_d    [2];
  logic signed [XLEN-1:0] src_val [2];
  logic                   src_haz [2];

  logic                   hazard;
  logic                   out_blocked;
  logic                   issue;
  logic                   accept;
  logic                   inc_v;
  logic                   dec_v;
  logic signed [XLEN-1:0] imm_v;
  logic signed [XLEN-1:0] opa;
  logic signed [XLEN-1:0] opb;

  assign rs[0]   = bus.in_instr[19:15];
  assign rs[1]   = bus.in_instr[24:20];
  assign rf_d[0] = rf_rs1_data;
  assign rf_d[1] = rf_rs2_data;

  // ---- stage p0: source resolution and operand selection ----
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      src_val[i] = '0;
      src_haz[i] = 1'b0;
      if (rs[i] != 5'd0) begin
        if (ex_fwd_valid && ex_fwd_rd == rs[i]) begin
          src_val[i] = ex_fwd_data;
          src_haz[i] = !ex_fwd_ready;
        end else if (mem_fwd_valid && mem_fwd_rd == rs[i]) begin
          src_val[i] = mem_fwd_data;
          src_haz[i] = !mem_fwd_ready;
        end else begin
          src_val[i] = rf_d[i];
          src_haz[i] = (pend[rs[i]] != '0);
        end
        // The held entry has not issued yet, so nothing downstream can forward it.
        if (vld_p1 && rd_we_p1 && rd_p1 == rs[i]) src_haz[i] = 1'b1;
      end
    end
  end

  assign hazard = (bus.in_use_rs1 && src_haz[0]) || (bus.in_use_rs2 && src_haz[1]);
  assign imm_v  = imm_gen(bus.in_instr, bus.in_imm_type);

  always_comb begin
    opa = '0;
    case (bus.in_sel_a)
      2'd0:    opa = ext_op(src_val[0], bus.in_ext);
      2'd1:    opa = XLEN'(bus.in_pc);
      default: opa = '0;
    endcase
    opb = '0;
    case (bus.in_sel_b)
      2'd0:    opb = ext_op(src_val[1], bus.in_ext);
      2'd1:    opb = imm_v;
      2'd2:    opb = XLEN'(4);
      default: opb = '0;
    endcase
  end

  assign out_blocked  = rd_we_p1 && rd_p1 != 5'd0 && pend[rd_p1] == PMAX;
  assign bus.out_valid = vld_p1 && !out_blocked;
  assign issue        = bus.out_valid && bus.out_ready;
  // A held entry stalled by a saturated counter must not be overwritten.
  assign bus.in_ready = !hazard && (!vld_p1 || issue) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign stall        = bus.in_valid && hazard;

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      rd_p1    <= '0;
      rd_we_p1 <= 1'b0;
      wmode_p1 <= 1'b0;
      rd1_p1   <= '0;
      rd2_p1   <= '0;
      imm_p1   <= '0;
    end else begin
      if (flush)       vld_p1 <= 1'b0;
      else if (accept) vld_p1 <= 1'b1;
      else if (issue)  vld_p1 <= 1'b0;
      if (accept) begin
        pc_p1    <= bus.in_pc;
        rd_p1    <= bus.in_instr[11:7];
        rd_we_p1 <= bus.in_rd_we;
        wmode_p1 <= (XLEN > 32) ? bus.in_wmode : 1'b0;
        rd1_p1   <= opa;
        rd2_p1   <= opb;
        imm_p1   <= imm_v;
      end
    end
  end

  assign bus.out_pc    = pc_p1;
  assign bus.out_rd    = rd_p1;
  assign bus.out_rd_we = rd_we_p1;
  assign bus.out_wmode = wmode_p1;
  assign bus.out_rd1   = rd1_p1;
  assign bus.out_rd2   = rd2_p1;
  assign bus.out_imm   = imm_p1;

  assign inc_v = issue && rd_we_p1 && rd_p1 != 5'd0;
  assign dec_v = wb_valid && wb_rd != 5'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (inc_v && rd_p1 == 5'(r) && !(dec_v && wb_rd == 5'(r)))
          pend[r] <= pend[r] + 1'b1;
        else if (dec_v && wb_rd == 5'(r) && !(inc_v && rd_p1 == 5'(r)) && pend[r] != '0)
          pend[r] <= pend[r] - 1'b1;
      end
    end
  end

  wb_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(dec_v && pend[wb_rd] == '0 && !(inc_v && rd_p1 == wb_rd)));

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed cases plus random traffic against a cycle-level
// reference model built from the instruction-format and hazard rules.
module tb_operand_stage;
  localparam int XLEN  = 64;
  localparam int NREG  = 32;
  localparam int CNT_W = 2;
  localparam int PMAX  = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
  logic            ex_fwd_valid, ex_fwd_ready;
  logic [4:0]      ex_fwd_rd;
  logic [XLEN-1:0] ex_fwd_data;
  logic            mem_fwd_valid, mem_fwd_ready;
  logic [4:0]      mem_fwd_rd;
  logic [XLEN-1:0] mem_fwd_data;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            stall;

  operand_stage_if #(.XLEN(XLEN)) bus ();

  operand_stage #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_ready(ex_fwd_ready),
    .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_ready(mem_fwd_ready),
    .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: one held entry plus outstanding-write counts per register.
  int          pend [NREG];
  bit          m_held, m_we, m_wm;
  logic [4:0]  m_rd;
  logic [63:0] m_pc, m_rd1, m_rd2, m_imm;

  function automatic logic [63:0] imm_ref(input logic [31:0] ins, input logic [2:0] t);
    longint s;
    s = longint'($signed(ins));
    case (t)
      3'd1: return s >>> 20;
      3'd2: return ((s >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd3: return ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                   | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      3'd4: return (s >>> 12) <<< 12;
      3'd5: return ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                   | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] ext_ref(input logic [63:0] v, input logic [1:0] e);
    if (e == 2'd1) return longint'($signed(v[31:0]));
    if (e == 2'd2) return v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic resolve_ref(input logic [4:0] rs, input logic [63:0] rf,
                             output logic [63:0] val, output bit haz);
    val = 64'd0;
    haz = 1'b0;
    if (rs != 5'd0) begin
      if (ex_fwd_valid && ex_fwd_rd == rs) begin
        val = ex_fwd_data; haz = !ex_fwd_ready;
      end else if (mem_fwd_valid && mem_fwd_rd == rs) begin
        val = mem_fwd_data; haz = !mem_fwd_ready;
      end else begin
        val = rf; haz = (pend[rs] != 0);
      end
      if (m_held && m_we && m_rd == rs) haz = 1'b1;
    end
  endtask

  // Called just after a falling edge with inputs driven; checks, advances model, waits one cycle.
  task automatic step();
    logic [63:0] v1, v2, a, b, imm;
    bit h1, h2, hz, ov, rdy, iss, acc, inc, dec;
    #1;
    resolve_ref(bus.in_instr[19:15], rf_rs1_data, v1, h1);
    resolve_ref(bus.in_instr[24:20], rf_rs2_data, v2, h2);
    hz  = (bus.in_use_rs1 && h1) || (bus.in_use_rs2 && h2);
    ov  = m_held && !(m_we && m_rd != 5'd0 && pend[m_rd] == PMAX);
    rdy = !hz && (!m_held || (ov && bus.out_ready)) && !flush;
    chk("stall", stall, bus.in_valid && hz);
    chk("in_ready", bus.in_ready, rdy);
    chk("out_valid", bus.out_valid, ov);
    if (m_held) begin
      chk("out_pc", bus.out_pc, m_pc);
      chk("out_rd", bus.out_rd, m_rd);
      chk("out_rd_we", bus.out_rd_we, m_we);
      chk("out_wmode", bus.out_wmode, m_wm);
      chk("out_rd1", bus.out_rd1, m_rd1);
      chk("out_rd2", bus.out_rd2, m_rd2);
      chk("out_imm", bus.out_imm, m_imm);
    end
    imm = imm_ref(bus.in_instr, bus.in_imm_type);
    a = (bus.in_sel_a == 2'd0) ? ext_ref(v1, bus.in_ext) :
        (bus.in_sel_a == 2'd1) ? bus.in_pc : 64'd0;
    b = (bus.in_sel_b == 2'd0) ? ext_ref(v2, bus.in_ext) :
        (bus.in_sel_b == 2'd1) ? imm :
        (bus.in_sel_b == 2'd2) ? 64'd4 : 64'd0;
    iss = ov && bus.out_ready;
    acc = bus.in_valid && rdy;
    inc = iss && m_we && m_rd != 5'd0;
    dec = wb_valid && wb_rd != 5'd0;
    if (inc && !(dec && wb_rd == m_rd)) pend[m_rd]++;
    if (dec && !(inc && wb_rd == m_rd) && pend[wb_rd] > 0) pend[wb_rd]--;
    if (flush) m_held = 1'b0;
    else if (acc) begin
      m_held = 1'b1;
      m_pc   = bus.in_pc;
      m_rd   = bus.in_instr[11:7];
      m_we   = bus.in_rd_we;
      m_wm   = bus.in_wmode;
      m_rd1  = a;
      m_rd2  = b;
      m_imm  = imm;
    end else if (iss) m_held = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] it,
                       input logic [1:0] sa, input logic [1:0] sb,
                       input bit u1, input bit u2, input bit we,
                       input logic [1:0] ext, input logic [63:0] pc);
    bus.in_valid    = 1'b1;
    bus.in_instr    = ins;
    bus.in_imm_type = it;
    bus.in_sel_a    = sa;
    bus.in_sel_b    = sb;
    bus.in_use_rs1  = u1;
    bus.in_use_rs2  = u2;
    bus.in_rd_we    = we;
    bus.in_ext      = ext;
    bus.in_wmode    = (ext != 2'd0);
    bus.in_pc       = pc;
  endtask

  task automatic quiet();
    bus.in_valid  = 1'b0;
    ex_fwd_valid  = 1'b0;
    mem_fwd_valid = 1'b0;
    wb_valid      = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) pend[r] = 0;
    m_held = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    quiet();
    drive(32'h0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 64'h0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rf_rs1_data = '0; rf_rs2_data = '0;
    ex_fwd_ready = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0;
    mem_fwd_ready = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_rd = '0;
    model_reset();

    @(negedge clk); #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_out_pc", bus.out_pc, 64'd0);
    chk("rst_out_rd1", bus.out_rd1, 64'd0);
    chk("rst_out_rd2", bus.out_rd2, 64'd0);
    chk("rst_out_imm", bus.out_imm, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // ADDI x5,x0,-1
    drive(32'hFFF0_0293, 3'd1, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 64'h1000);
    step(); quiet(); #1;
    chk("addi_rd2", bus.out_rd2, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_rd1", bus.out_rd1, 64'd0);
    chk("addi_valid", bus.out_valid, 1'b1);
    step();

    // BEQ with imm -4096, then JAL x1,+2
    drive(32'h8000_0063, 3'd3, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 64'h1004);
    step(); quiet(); #1;
    chk("beq_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_F000);
    drive(32'h0020_00EF, 3'd5, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 2'd0, 64'h8000_1000);
    step(); quiet(); #1;
    chk("jal_imm", bus.out_imm, 64'd2);
    chk("jal_rd1", bus.out_rd1, 64'h8000_1000);
    chk("jal_rd2", bus.out_rd2, 64'd4);
    step();

    // Load-use on x6 through EX
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd6; ex_fwd_ready = 1'b0; ex_fwd_data = 64'd0;
    drive(32'h0003_0533, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd0, 64'h2000);
    #1;
    chk("load_stall", stall, 1'b1);
    chk("load_in_ready", bus.in_ready, 1'b0);
    step();
    ex_fwd_ready = 1'b1; ex_fwd_data = 64'h1234;
    step(); quiet(); #1;
    chk("load_fwd_rd1", bus.out_rd1, 64'h1234);

    // EX beats MEM on x7
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd7; ex_fwd_ready = 1'b1; ex_fwd_data = 64'hA;
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_ready = 1'b1; mem_fwd_data = 64'hB;
    drive(32'h0003_85B3, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd0, 64'h2004);
    step(); quiet(); #1;
    chk("prio_rd1", bus.out_rd1, 64'hA);

    // DIVW x12,x8 with sign- and zero-extension of the low word
    rf_rs1_data = 64'h0000_0000_8000_0000;
    drive(32'h0204_463B, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1, 64'h2008);
    step(); #1;
    chk("divw_sext", bus.out_rd1, 64'hFFFF_FFFF_8000_0000);
    drive(32'h0204_463B, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 64'h200C);
    step(); quiet(); #1;
    chk("divw_zext", bus.out_rd1, 64'h0000_0000_8000_0000);
    step();

    // Saturate the x9 counter, then release via writeback
    for (int k = 0; k <= PMAX; k++) begin
      drive(32'h0010_0493, 3'd1, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 64'h3000 + 64'(4 * k));
      step();
    end
    quiet(); #1;
    chk("sat_hold", bus.out_valid, 1'b0);
    step(); step();
    wb_valid = 1'b1; wb_rd = 5'd9; #1;
    chk("sat_hold_wb", bus.out_valid, 1'b0);
    step();
    wb_valid = 1'b0; #1;
    chk("sat_release", bus.out_valid, 1'b1);
    step();
    wb_valid = 1'b1; wb_rd = 5'd9;
    drive(32'h0010_0493, 3'd1, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 64'h3100);
    step();
    bus.in_valid = 1'b0; #1;
    chk("same_cycle_valid", bus.out_valid, 1'b1);
    step();
    wb_valid = 1'b0;
    drive(32'h0010_0493, 3'd1, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 64'h3104);
    step(); quiet(); #1;
    chk("same_cycle_net", bus.out_valid, 1'b1);
    step();
    for (int k = 0; k < 8 && pend[9] > 0; k++) begin
      wb_valid = 1'b1; wb_rd = 5'd9;
      step();
    end
    quiet();

    // flush drops the held entry and refuses the concurrent input
    bus.out_ready = 1'b0;
    drive(32'h0010_0693, 3'd1, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 64'h4000);
    step();
    drive(32'h0010_0713, 3'd1, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 64'h4004);
    flush = 1'b1; #1;
    chk("flush_in_ready", bus.in_ready, 1'b0);
    step();
    quiet(); #1;
    chk("flush_drop", bus.out_valid, 1'b0);
    drive(32'h0006_87B3, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd0, 64'h4008);
    #1;
    chk("flush_no_pend", stall, 1'b0);
    step();
    bus.out_ready = 1'b1;
    quiet();
    step();

    // Random traffic over x0..x7
    for (int n = 0; n < 1500; n++) begin
      int r;
      bus.in_valid         = ($urandom_range(0, 3) != 0);
      bus.in_instr         = $urandom;
      bus.in_instr[19:15]  = 5'($urandom_range(0, 7));
      bus.in_instr[24:20]  = 5'($urandom_range(0, 7));
      bus.in_instr[11:7]   = 5'($urandom_range(0, 7));
      bus.in_imm_type      = 3'($urandom_range(0, 5));
      bus.in_sel_a         = 2'($urandom_range(0, 2));
      bus.in_sel_b         = 2'($urandom_range(0, 2));
      bus.in_use_rs1       = 1'($urandom);
      bus.in_use_rs2       = 1'($urandom);
      bus.in_rd_we         = 1'($urandom);
      bus.in_ext           = 2'($urandom_range(0, 2));
      bus.in_wmode         = 1'($urandom);
      bus.in_pc            = {$urandom, $urandom};
      rf_rs1_data          = {$urandom, $urandom};
      rf_rs2_data          = {$urandom, $urandom};
      ex_fwd_valid         = ($urandom_range(0, 2) == 0);
      ex_fwd_ready         = 1'($urandom);
      ex_fwd_rd            = 5'($urandom_range(0, 7));
      ex_fwd_data          = {$urandom, $urandom};
      mem_fwd_valid        = ($urandom_range(0, 2) == 0);
      mem_fwd_ready        = 1'($urandom);
      mem_fwd_rd           = 5'($urandom_range(0, 7));
      mem_fwd_data         = {$urandom, $urandom};
      r                    = $urandom_range(1, 7);
      wb_rd                = 5'(r);
      wb_valid             = (pend[r] > 0) && ($urandom_range(0, 1) == 1);
      bus.out_ready        = ($urandom_range(0, 3) != 0);
      flush                = ($urandom_range(0, 31) == 0);
      step();
    end

    // Reset mid-stream with a pending x4 writer and a held entry
    quiet();
    bus.out_ready = 1'b1;
    step(); step();
    drive(32'h0010_0213, 3'd1, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 64'h5000);
    step(); quiet(); step();
    bus.out_ready = 1'b0;
    drive(32'h0010_0193, 3'd1, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 64'h5004);
    step(); quiet();
    #3 reset = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_out_rd1", bus.out_rd1, 64'd0);
    chk("midrst_out_pc", bus.out_pc, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    drive(32'h0002_02B3, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd0, 64'h6000);
    #1;
    chk("midrst_no_pend", stall, 1'b0);
    step(); quiet(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
